// File: rtl/prf_commit_sched.sv
// ---------------------------------------------------------------------------
// uarch_pkg: shared micro-architecture sizes and the PRF commit write-port
// record used between ROB retirement and the physical register file.
// ---------------------------------------------------------------------------
package uarch_pkg;
    localparam int ARCH_REGS     = 32;
    localparam int TAG_WIDTH     = 6;
    localparam int CPU_DATA_BITS = 32;
    localparam int ADDR_W        = $clog2(ARCH_REGS);

    typedef struct packed {
        logic                     we;
        logic [ADDR_W-1:0]        addr;
        logic [TAG_WIDTH-1:0]     tag;
        logic [CPU_DATA_BITS-1:0] data;
    } prf_commit_write_port_t;
endpackage

// ---------------------------------------------------------------------------
// prf_commit_sched
//   Small circular FIFO between ROB retirement and the two PRF commit write
//   ports. Accepts up to two retiring entries per cycle and presents the two
//   oldest buffered entries on the commit ports, oldest on port 0. While
//   flush is high nothing drains (the PRF would drop the writes), so entries
//   are held and drain once flush drops.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   flush                  pipeline flush; blocks pops and write enables
//   in_valid_0/1, in_0/1   retiring entries from the ROB (0 is older);
//                          the incoming 'we' field is ignored
//   in_ready               both offered entries will be taken this cycle
//   commit_0/1_write_port  oldest / second-oldest buffered entry
//   count, empty           occupancy
// ---------------------------------------------------------------------------
module prf_commit_sched
    import uarch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid_0,
    input  logic                   in_valid_1,
    input  prf_commit_write_port_t in_0,
    input  prf_commit_write_port_t in_1,
    output logic                   in_ready,
    output prf_commit_write_port_t commit_0_write_port,
    output prf_commit_write_port_t commit_1_write_port,
    output logic [CNT_W-1:0]       count,
    output logic                   empty
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int NUM_PORT = 2;

    // Stored record: the write enable is recomputed on the way out.
    typedef struct packed {
        logic [ADDR_W-1:0]        addr;
        logic [TAG_WIDTH-1:0]     tag;
        logic [CPU_DATA_BITS-1:0] data;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] cnt_q;

    logic [1:0]       n_push;
    logic [1:0]       n_pop;
    logic             wr_0;
    logic             wr_1;
    entry_t           wr_data_0;
    entry_t           wr_data_1;
    logic [PTR_W-1:0] tail_p1;

    // Room for a full pair is required before anything is taken, so the
    // ROB handshake never depends on same-cycle pops or on the valids.
    assign in_ready = ({1'b0, cnt_q} + (CNT_W + 1)'(2)) <= (CNT_W + 1)'(DEPTH);

    assign tail_p1  = tail + PTR_W'(1);

    // ------------------------------------------------------------------
    // Push/pop decode
    // ------------------------------------------------------------------
    always_comb begin
        n_push    = 2'd0;
        wr_0      = 1'b0;
        wr_1      = 1'b0;
        // A lone in_valid_1 lands in the tail slot, same as a lone entry 0.
        wr_data_0 = in_valid_0 ? entry_t'{addr: in_0.addr, tag: in_0.tag, data: in_0.data}
                               : entry_t'{addr: in_1.addr, tag: in_1.tag, data: in_1.data};
        wr_data_1 = entry_t'{addr: in_1.addr, tag: in_1.tag, data: in_1.data};
        if (in_ready) begin
            wr_0   = in_valid_0 | in_valid_1;
            wr_1   = in_valid_0 & in_valid_1;
            n_push = {1'b0, in_valid_0} + {1'b0, in_valid_1};
        end
    end

    always_comb begin
        n_pop = 2'd0;
        if (!flush) begin
            if (cnt_q >= CNT_W'(2)) n_pop = 2'd2;
            else                    n_pop = cnt_q[1:0];
        end
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            cnt_q <= '0;
        end else begin
            head  <= head + PTR_W'(n_pop);
            tail  <= tail + PTR_W'(n_push);
            cnt_q <= cnt_q + CNT_W'(n_push) - CNT_W'(n_pop);
        end
    end

    // Storage needs no reset: nothing is visible with we=1 until written.
    always_ff @(posedge clk) begin
        if (wr_0) mem[tail]    <= wr_data_0;
        if (wr_1) mem[tail_p1] <= wr_data_1;
    end

    // ------------------------------------------------------------------
    // Commit ports: slot i reads head+i. Data is always driven from
    // storage; only the enable is qualified. Writes to x0 still pop.
    // ------------------------------------------------------------------
    prf_commit_write_port_t port [NUM_PORT];

    for (genvar i = 0; i < NUM_PORT; i++) begin : g_port
        logic [PTR_W-1:0] rd_ptr;
        entry_t           rd;

        assign rd_ptr = head + PTR_W'(i);
        assign rd     = mem[rd_ptr];

        always_comb begin
            port[i].addr = rd.addr;
            port[i].tag  = rd.tag;
            port[i].data = rd.data;
            port[i].we   = (cnt_q > CNT_W'(i)) && !flush && (rd.addr != '0);
        end
    end

    assign commit_0_write_port = port[0];
    assign commit_1_write_port = port[1];
    assign count               = cnt_q;
    assign empty               = (cnt_q == '0);

endmodule

// File: tb/tb_prf_commit_sched.sv
module tb_prf_commit_sched;
    import uarch_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                   clk;
    logic                   rst_n;
    logic                   flush;
    logic                   in_valid_0;
    logic                   in_valid_1;
    prf_commit_write_port_t in_0;
    prf_commit_write_port_t in_1;
    logic                   in_ready;
    prf_commit_write_port_t commit_0_write_port;
    prf_commit_write_port_t commit_1_write_port;
    logic [CNT_W-1:0]       count;
    logic                   empty;

    int tests = 0;
    int fails = 0;

    // Scoreboard: entries in expected program order.
    prf_commit_write_port_t mq[$];
    // Downstream PRF model (port 1 written last, so it wins).
    logic [CPU_DATA_BITS-1:0] prf [ARCH_REGS];

    prf_commit_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .flush               (flush),
        .in_valid_0          (in_valid_0),
        .in_valid_1          (in_valid_1),
        .in_0                (in_0),
        .in_1                (in_1),
        .in_ready            (in_ready),
        .commit_0_write_port (commit_0_write_port),
        .commit_1_write_port (commit_1_write_port),
        .count               (count),
        .empty               (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!flush) begin
            if (commit_0_write_port.we) prf[commit_0_write_port.addr] <= commit_0_write_port.data;
            if (commit_1_write_port.we) prf[commit_1_write_port.addr] <= commit_1_write_port.data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1, "watchdog");
    end

    function automatic prf_commit_write_port_t mk(input int a, input int t, input int d);
        prf_commit_write_port_t e;
        e.we   = 1'b0;
        e.addr = ADDR_W'(a);
        e.tag  = TAG_WIDTH'(t);
        e.data = CPU_DATA_BITS'(d);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every visible output against the scoreboard model.
    task automatic check_outputs(input string tag);
        int sz;
        prf_commit_write_port_t p;
        sz = mq.size();
        chk({tag, " count"},    64'(count),    64'(sz));
        chk({tag, " empty"},    64'(empty),    64'(sz == 0));
        chk({tag, " in_ready"}, 64'(in_ready), 64'((DEPTH - sz) >= 2));
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? commit_0_write_port : commit_1_write_port;
            chk($sformatf("%s p%0d we", tag, k), 64'(p.we),
                64'((sz > k) && !flush && (sz > k ? mq[k].addr != 0 : 1'b0)));
            if (sz > k) begin
                chk($sformatf("%s p%0d addr", tag, k), 64'(p.addr), 64'(mq[k].addr));
                chk($sformatf("%s p%0d tag", tag, k),  64'(p.tag),  64'(mq[k].tag));
                chk($sformatf("%s p%0d data", tag, k), 64'(p.data), 64'(mq[k].data));
            end
        end
    endtask

    // One cycle: drive at negedge, check, clock, update model.
    task automatic cyc(input string tag, input bit v0, input prf_commit_write_port_t e0,
                       input bit v1, input prf_commit_write_port_t e1, input bit fl);
        int sz;
        bit acc;
        int np;
        flush      = fl;
        in_valid_0 = v0;
        in_valid_1 = v1;
        in_0       = e0;
        in_1       = e1;
        #1;
        check_outputs(tag);
        sz  = mq.size();
        acc = (DEPTH - sz) >= 2;
        np  = fl ? 0 : (sz > 2 ? 2 : sz);
        @(posedge clk);
        for (int k = 0; k < np; k++) void'(mq.pop_front());
        if (acc) begin
            if (v0) mq.push_back(e0);
            if (v1) mq.push_back(e1);
        end
        @(negedge clk);
    endtask

    prf_commit_write_port_t z;

    initial begin
        z          = mk(0, 0, 0);
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid_0 = 1'b0;
        in_valid_1 = 1'b0;
        in_0       = z;
        in_1       = z;
        for (int r = 0; r < ARCH_REGS; r++) prf[r] = '0;

        // Reset state
        #3;
        chk("rst count",    64'(count),                  64'(0));
        chk("rst empty",    64'(empty),                  64'(1));
        chk("rst in_ready", 64'(in_ready),               64'(1));
        chk("rst we0",      64'(commit_0_write_port.we), 64'(0));
        chk("rst we1",      64'(commit_1_write_port.we), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic pair, one-cycle latency, then empty
        cyc("pair push", 1, mk(5, 3, 'hAA), 1, mk(6, 4, 'hBB), 0);
        chk("pair p0 data", 64'(commit_0_write_port.data), 64'('hAA));
        chk("pair p1 data", 64'(commit_1_write_port.data), 64'('hBB));
        cyc("pair out", 0, z, 0, z, 0);
        cyc("pair drained", 0, z, 0, z, 0);
        chk("pair empty", 64'(empty), 64'(1));

        // Fill under flush; third pair refused; drain after flush drops
        cyc("fl 0", 1, mk(1, 1, 'h101), 1, mk(2, 2, 'h102), 1);
        cyc("fl 1", 1, mk(3, 3, 'h103), 1, mk(4, 4, 'h104), 1);
        cyc("fl 2", 1, mk(8, 5, 'h105), 1, mk(9, 6, 'h106), 1);
        chk("fl full count", 64'(count), 64'(4));
        cyc("fl drain a", 0, z, 0, z, 0);
        cyc("fl drain b", 0, z, 0, z, 0);
        cyc("fl done", 0, z, 0, z, 0);

        // Same destination: younger (port 1) wins in the PRF
        cyc("x7 push", 1, mk(7, 1, 'h11), 1, mk(7, 2, 'h22), 0);
        cyc("x7 out", 0, z, 0, z, 0);
        cyc("x7 after", 0, z, 0, z, 0);
        chk("x7 prf", 64'(prf[7]), 64'('h22));

        // x0 pops silently
        cyc("x0 push", 1, mk(0, 1, 'hFF), 1, mk(3, 2, 'h33), 0);
        cyc("x0 out", 0, z, 0, z, 0);
        cyc("x0 after", 0, z, 0, z, 0);
        chk("x3 prf", 64'(prf[3]), 64'('h33));

        // Lone in_valid_1 refused at count 3, accepted after a pop
        cyc("v1 fill a", 1, mk(10, 1, 'hA1), 1, mk(11, 2, 'hA2), 1);
        cyc("v1 fill b", 1, mk(12, 3, 'hA3), 0, z, 1);
        cyc("v1 refused", 0, z, 1, mk(9, 7, 'h99), 0);
        cyc("v1 accepted", 0, z, 1, mk(9, 7, 'h99), 0);
        cyc("v1 order", 0, z, 0, z, 0);
        cyc("v1 done", 0, z, 0, z, 0);
        chk("x9 prf", 64'(prf[9]), 64'('h99));

        // Short random traffic
        for (int i = 0; i < 40; i++) begin
            cyc($sformatf("rnd %0d", i),
                $urandom_range(1, 0), mk($urandom_range(31, 0), $urandom_range(63, 0), $urandom),
                $urandom_range(1, 0), mk($urandom_range(31, 0), $urandom_range(63, 0), $urandom),
                $urandom_range(3, 0) == 0);
        end
        for (int i = 0; i < 3; i++) cyc("rnd drain", 0, z, 0, z, 0);

        // Asynchronous reset mid-drain at count 3
        cyc("ar fill a", 1, mk(13, 1, 'hC1), 1, mk(14, 2, 'hC2), 1);
        cyc("ar fill b", 1, mk(15, 3, 'hC3), 0, z, 1);
        flush      = 1'b0;
        in_valid_0 = 1'b0;
        in_valid_1 = 1'b0;
        #1;
        check_outputs("ar pre");
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar count",    64'(count),                  64'(0));
        chk("ar empty",    64'(empty),                  64'(1));
        chk("ar in_ready", 64'(in_ready),               64'(1));
        chk("ar we0",      64'(commit_0_write_port.we), 64'(0));
        chk("ar we1",      64'(commit_1_write_port.we), 64'(0));
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cyc("ar post", 0, z, 0, z, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
